// File: rtl/scratch_ram_stack_if.sv
// scratch_ram_stack_if: data, command and status bundle of the scratch RAM / stack
interface scratch_ram_stack_if #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 8
);
    logic [DATA_W-1:0] DATA_IN;
    logic [ADDR_W-1:0] SCR_ADDR;
    logic              SCR_WE;
    logic              PUSH;
    logic              POP;
    logic              SP_LD;
    logic [ADDR_W-1:0] SP_DATA;
    logic              ERR_CLR;
    logic [DATA_W-1:0] DATA_OUT;
    logic [ADDR_W-1:0] SP;
    logic              FULL;
    logic              EMPTY;
    logic              OVF;
    logic              UNF;
    logic              BUSY;
    modport master (
        output DATA_IN, SCR_ADDR, SCR_WE, PUSH, POP, SP_LD, SP_DATA, ERR_CLR,
        input  DATA_OUT, SP, FULL, EMPTY, OVF, UNF, BUSY
    );
    modport slave (
        input  DATA_IN, SCR_ADDR, SCR_WE, PUSH, POP, SP_LD, SP_DATA, ERR_CLR,
        output DATA_OUT, SP, FULL, EMPTY, OVF, UNF, BUSY
    );
endinterface

// File: rtl/scratch_ram_stack.sv
// scratch_ram_stack: scratch RAM with registered read, downward-growing hardware stack
// and optional post-reset zeroing sweep
module scratch_ram_stack #(
    parameter int DATA_W       = 10,
    parameter int ADDR_W       = 8,
    parameter bit CLEAR_ON_RST = 1'b1
) (
    input logic CLK,
    input logic RST,
    scratch_ram_stack_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [0:0] ST_RUN = 1'b0;
    localparam logic [0:0] ST_CLR = 1'b1;
    localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [0:0]        st_q, st_d;
    logic [ADDR_W-1:0] idx_q, idx_d, sp_q, sp_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              busy, full, empty, do_push, do_pop, we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    assign busy    = st_q == ST_CLR;
    assign full    = cnt_q == CNT_FULL;
    assign empty   = cnt_q == '0;
    assign do_push = !busy && !bus.SP_LD && bus.PUSH && !bus.POP;
    assign do_pop  = !busy && !bus.SP_LD && bus.POP && !bus.PUSH;

    always_comb begin
        we     = !RST && (busy || (do_push && !full) ||
                 (!busy && !bus.SP_LD && !bus.PUSH && !bus.POP && bus.SCR_WE));
        waddr  = busy ? idx_q : do_push ? sp_q - 1'b1 : bus.SCR_ADDR;
        wdata  = busy ? '0 : bus.DATA_IN;
        st_d   = (busy && &idx_q) ? ST_RUN : st_q;
        idx_d  = busy ? idx_q + 1'b1 : idx_q;
        sp_d   = busy ? sp_q : bus.SP_LD ? bus.SP_DATA :
                 (do_push && !full) ? sp_q - 1'b1 : (do_pop && !empty) ? sp_q + 1'b1 : sp_q;
        // SP counts down from the top, so occupancy is the distance to wrap
        cnt_d  = busy ? cnt_q : bus.SP_LD ? {1'b0, -bus.SP_DATA} :
                 (do_push && !full) ? cnt_q + 1'b1 : (do_pop && !empty) ? cnt_q - 1'b1 : cnt_q;
        dout_d = busy ? '0 : do_pop ? (empty ? dout_q : mem[sp_q]) : mem[bus.SCR_ADDR];
        ovf_d  = busy ? ovf_q : (do_push && full) || (ovf_q && !bus.ERR_CLR);
        unf_d  = busy ? unf_q : (do_pop && empty) || (unf_q && !bus.ERR_CLR);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            st_q   <= CLEAR_ON_RST ? ST_CLR : ST_RUN;
            idx_q  <= '0;
            sp_q   <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            idx_q  <= idx_d;
            sp_q   <= sp_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= wdata;
    end

    assign bus.DATA_OUT = dout_q;
    assign bus.SP       = sp_q;
    assign bus.FULL     = full;
    assign bus.EMPTY    = empty;
    assign bus.OVF      = ovf_q;
    assign bus.UNF      = unf_q;
    assign bus.BUSY     = busy;
endmodule
